mem_link_initiator: RTL and testbench
=====================================

# mem_link_initiator

CPU-side initiator for the serial memory link: accepts one word-wide memory request at a time, packs it into a channel message (5-byte read or 9-byte write), hands it to the channel transmit port, and for reads waits for the 4-byte reply on the channel receive port. Sits between the CPU memory stage and the channel multiplexer that feeds the UART, mirroring the memory responder on the far end of the link.

## Interface
- TIMEOUT, 1048576: cycles to wait for a read reply before flagging an error.
- TO_BITS, 21: width of the timeout counter; must hold TIMEOUT.
- EXCLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = write, 0 = read.
- addr  in  32  byte address.
- wdata  in  32  write data, little-endian (byte 0 = wdata[7:0] to addr).
- wmask  in  4  byte enables; bit i enables byte addr+i.
- busy  out  1  request in progress.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  read data; valid from done onward, held until the next read completes.
- err  out  1  one-cycle error pulse.
- tx_flag  out  1  one-cycle push of a message to the channel.
- tx_len  out  5  message length in bytes.
- tx_data  out  72  message payload.
- tx_ready  in  1  channel can accept a message.
- rx_valid  in  1  reply message available.
- rx_len  in  5  reply length in bytes.
- rx_data  in  72  reply payload.
- rx_flag  out  1  one-cycle pop of the reply message.

## Operation
- Message formats:
  - Read: tx_len=5; tx_data[31:0]=addr; tx_data[39:32]=0; rest 0.
  - Write: tx_len=9; [31:0]=wdata, [63:32]=addr, [67:64]=wmask, [71:68]=0.
- FSM states:
  - IDLE: req=1 latches we/addr/wdata/wmask, sets busy, goes to SEND.
  - SEND: when tx_ready=1, pulse tx_flag with the formatted message. A write goes to FIN. A read clears the timeout counter and goes to WAIT. While tx_ready=0, stay in SEND; no timeout applies.
  - WAIT: when rx_valid=1, pulse rx_flag.
    - rx_len==4: rdata<=rx_data[31:0], go to FIN.
    - Any other length: err pulse, go to FIN, rdata unchanged.
    - If the counter reaches TIMEOUT-1 with no reply: err pulse, go to FIN.
  - FIN: done pulse, busy cleared, back to IDLE. req is ignored in FIN.
- Error cycle: err is asserted in the cycle before done.
- Unsolicited reply: rx_valid in IDLE or SEND pops the message (rx_flag) and pulses err; FSM state is unchanged.
- Simultaneous events: a stray pop in SEND and a tx_flag push may occur in the same cycle.
- wmask=0 is still sent as a write.
- No address alignment check; addr is passed through unchanged.
- Reset mid-operation: FSM returns to IDLE immediately and the latched request is discarded. A late reply is later treated as unsolicited.

## Timing
- Reset values: busy=0, done=0, err=0, tx_flag=0, tx_len=0, tx_data=0, rx_flag=0, rdata=0; state IDLE; counter 0.
- All outputs are registered.
- Write latency: req at cycle 0 -> tx_flag at cycle 1 (if tx_ready) -> done at cycle 2.
- Read latency: tx_flag at cycle 1 -> rx_flag in the cycle after rx_valid is seen -> done one cycle later.
- tx_flag is high for exactly one cycle per request.
- rx_flag is high for exactly one cycle per consumed message; it is never high two consecutive cycles (gives the channel a cycle to drop rx_valid).
- busy rises the cycle after req is accepted and falls together with the done pulse.
- A new req is accepted no earlier than the first IDLE cycle after done.

## Test plan
- Write: req, we=1, addr=0x100, wdata=0xDEADBEEF, wmask=4'b0011, tx_ready=1 -> tx_flag one cycle, tx_len=9, tx_data=72'h03_00000100_DEADBEEF; done at cycle 2; no rx_flag.
- Read: req, we=0, addr=0x4; reply rx_len=4, rx_data=0x12345678 after 10 cycles -> tx_len=5, tx_data=0x0000000004; rx_flag one cycle; rdata=0x12345678 with done.
- Backpressure: tx_ready=0 for 50 cycles, then 1 -> busy stays high, a single tx_flag after tx_ready rises, no err.
- Errors:
  - Bad length: read reply with rx_len=9 -> err then done, rdata keeps its old value.
  - Timeout: TIMEOUT=16, no reply -> err after 16 WAIT cycles, then done.
- Stray reply: rx_valid in IDLE -> rx_flag and err pulse, busy stays 0; a following read completes normally.
- Reset: assert RST during WAIT -> all outputs 0 asynchronously. A reply arriving after reset is popped with err. A read then returns the correct data.

Source files
------------

// File: rtl/mem_link_initiator.sv
// CPU-side initiator for the serial memory link: turns one memory request into a
// 5-byte read or 9-byte write channel message and, for reads, collects the 4-byte reply.
module mem_link_initiator #(
  parameter int TIMEOUT = 1048576,
  parameter int TO_BITS = 21
) (
  input  logic        EXCLK,
  input  logic        RST,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wmask,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        tx_flag,
  output logic [4:0]  tx_len,
  output logic [71:0] tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [4:0]  rx_len,
  input  logic [71:0] rx_data,
  output logic        rx_flag
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, FIN} state_t;

  localparam logic [TO_BITS-1:0] LAST_COUNT = TO_BITS'(TIMEOUT - 1);

  state_t             state, state_nxt;
  logic               lat_we, lat_we_nxt;
  logic [31:0]        lat_addr, lat_addr_nxt;
  logic [31:0]        lat_wdata, lat_wdata_nxt;
  logic [3:0]         lat_wmask, lat_wmask_nxt;
  logic [TO_BITS-1:0] count, count_nxt;
  logic               busy_nxt, done_nxt, err_nxt, tx_flag_nxt, rx_flag_nxt;
  logic [4:0]         tx_len_nxt;
  logic [71:0]        tx_data_nxt;
  logic [31:0]        rdata_nxt;
  logic               pop, timed_out;
  logic               unused_rx;

  // A pop is withheld in the cycle right after one, so the channel can drop rx_valid.
  assign pop       = rx_valid && !rx_flag;
  assign timed_out = (count == LAST_COUNT);
  assign unused_rx = ^rx_data[71:32];

  always_ff @(posedge EXCLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      count     <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wmask <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      tx_flag   <= 1'b0;
      tx_len    <= '0;
      tx_data   <= '0;
      rx_flag   <= 1'b0;
      rdata     <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      lat_we    <= lat_we_nxt;
      lat_addr  <= lat_addr_nxt;
      lat_wdata <= lat_wdata_nxt;
      lat_wmask <= lat_wmask_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      tx_flag   <= tx_flag_nxt;
      tx_len    <= tx_len_nxt;
      tx_data   <= tx_data_nxt;
      rx_flag   <= rx_flag_nxt;
      rdata     <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = SEND;
      SEND:    if (tx_ready) state_nxt = lat_we ? FIN : WAIT;
      WAIT:    if (pop || timed_out) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A reply seen while not waiting for one is still consumed, but only flagged as an error.
  always_comb begin
    lat_we_nxt    = lat_we;
    lat_addr_nxt  = lat_addr;
    lat_wdata_nxt = lat_wdata;
    lat_wmask_nxt = lat_wmask;
    count_nxt     = count;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    tx_flag_nxt   = 1'b0;
    tx_len_nxt    = tx_len;
    tx_data_nxt   = tx_data;
    rx_flag_nxt   = 1'b0;
    rdata_nxt     = rdata;
    case (state)
      IDLE: begin
        if (req) begin
          busy_nxt      = 1'b1;
          lat_we_nxt    = we;
          lat_addr_nxt  = addr;
          lat_wdata_nxt = wdata;
          lat_wmask_nxt = wmask;
        end
        if (pop) begin
          rx_flag_nxt = 1'b1;
          err_nxt     = 1'b1;
        end
      end
      SEND: begin
        if (pop) begin
          rx_flag_nxt = 1'b1;
          err_nxt     = 1'b1;
        end
        if (tx_ready) begin
          tx_flag_nxt = 1'b1;
          count_nxt   = '0;
          if (lat_we) begin
            tx_len_nxt  = 5'd9;
            tx_data_nxt = {4'h0, lat_wmask, lat_addr, lat_wdata};
          end else begin
            tx_len_nxt  = 5'd5;
            tx_data_nxt = {40'h0, lat_addr};
          end
        end
      end
      WAIT: begin
        if (pop) begin
          rx_flag_nxt = 1'b1;
          if (rx_len == 5'd4) rdata_nxt = rx_data[31:0];
          else err_nxt = 1'b1;
        end else if (timed_out) begin
          err_nxt = 1'b1;
        end else begin
          count_nxt = count + TO_BITS'(1);
        end
      end
      FIN: begin
        done_nxt = 1'b1;
        busy_nxt = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_link_initiator.sv
// Self-checking bench for mem_link_initiator: directed scenarios with random payloads,
// compared against a byte-level message model and a simple rdata/latency model.
module tb_mem_link_initiator;

  localparam int TIMEOUT = 16;
  localparam int TO_BITS = 5;

  logic        EXCLK = 1'b0;
  logic        RST;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  wmask;
  logic        busy, done, err, tx_flag, rx_flag;
  logic [31:0] rdata;
  logic [4:0]  tx_len, rx_len;
  logic [71:0] tx_data, rx_data;
  logic        tx_ready, rx_valid;

  int n_compared = 0;
  int n_mismatched = 0;

  int cyc, req_cyc, tx_cyc, rx_cyc, err_cyc, done_cyc, reply_cyc, rel_cyc;
  int n_tx, n_rx, n_err, n_done, n_busy, n_rx_back, busy_low;
  logic        prev_rx;
  logic [4:0]  cap_len;
  logic [71:0] cap_data;
  logic [31:0] cap_rdata;
  logic [31:0] model_rdata;
  logic [31:0] good_data;

  mem_link_initiator #(.TIMEOUT(TIMEOUT), .TO_BITS(TO_BITS)) dut (
    .EXCLK(EXCLK), .RST(RST), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .wmask(wmask), .busy(busy), .done(done), .rdata(rdata), .err(err),
    .tx_flag(tx_flag), .tx_len(tx_len), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_len(rx_len), .rx_data(rx_data), .rx_flag(rx_flag)
  );

  always #5 EXCLK = ~EXCLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: bench did not reach its end");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference message built byte by byte, in channel order.
  function automatic void expect_msg(input logic w, input logic [31:0] a, input logic [31:0] d,
                                     input logic [3:0] m, output logic [4:0] len,
                                     output logic [71:0] payload);
    logic [7:0] bytes[$];
    bytes = {};
    if (w) begin
      for (int i = 0; i < 4; i++) bytes.push_back(d[8*i +: 8]);
      for (int i = 0; i < 4; i++) bytes.push_back(a[8*i +: 8]);
      bytes.push_back({4'h0, m});
    end else begin
      for (int i = 0; i < 4; i++) bytes.push_back(a[8*i +: 8]);
      bytes.push_back(8'h00);
    end
    len = 5'(bytes.size());
    payload = '0;
    foreach (bytes[i]) payload[8*i +: 8] = bytes[i];
  endfunction

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge EXCLK);
    cyc++;
    if (tx_flag) begin
      n_tx++;
      tx_cyc   = cyc;
      cap_len  = tx_len;
      cap_data = tx_data;
    end
    if (rx_flag) begin
      n_rx++;
      rx_cyc = cyc;
      if (prev_rx) n_rx_back++;
    end
    prev_rx = rx_flag;
    if (err) begin
      n_err++;
      err_cyc = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc  = cyc;
      cap_rdata = rdata;
    end
    if (busy) n_busy++;
  endtask

  task automatic clear_counts();
    n_tx = 0; n_rx = 0; n_err = 0; n_done = 0; n_busy = 0;
  endtask

  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] m);
    we = w; addr = a; wdata = d; wmask = m; req = 1'b1;
    tick();
    req_cyc = cyc;
    req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (n_done == 0 && i < budget) begin
      tick();
      i++;
    end
    tick();
    tick();
    checkOutput("done_once", 72'(n_done), 72'(1));
  endtask

  task automatic send_reply(input logic [4:0] len, input logic [71:0] data, input int budget);
    int start = n_rx;
    int i = 0;
    rx_valid = 1'b1; rx_len = len; rx_data = data;
    reply_cyc = cyc;
    while (n_rx == start && i < budget) begin
      tick();
      i++;
    end
    rx_valid = 1'b0;
    checkOutput("rx_pop", 72'(n_rx - start), 72'(1));
  endtask

  task automatic check_all_zero(input string pfx);
    checkOutput({pfx, "_busy"},    72'(busy),    72'(0));
    checkOutput({pfx, "_done"},    72'(done),    72'(0));
    checkOutput({pfx, "_err"},     72'(err),     72'(0));
    checkOutput({pfx, "_tx_flag"}, 72'(tx_flag), 72'(0));
    checkOutput({pfx, "_tx_len"},  72'(tx_len),  72'(0));
    checkOutput({pfx, "_tx_data"}, tx_data,      72'(0));
    checkOutput({pfx, "_rx_flag"}, 72'(rx_flag), 72'(0));
    checkOutput({pfx, "_rdata"},   72'(rdata),   72'(0));
  endtask

  task automatic run_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                           input string tag);
    logic [4:0]  elen;
    logic [71:0] edata;
    expect_msg(1'b1, a, d, m, elen, edata);
    clear_counts();
    applyStimulus(1'b1, a, d, m);
    checkOutput({tag, "_busy_rise"}, 72'(busy), 72'(1));
    wait_done(20);
    checkOutput({tag, "_ntx"},     72'(n_tx), 72'(1));
    checkOutput({tag, "_len"},     72'(cap_len), 72'(elen));
    checkOutput({tag, "_data"},    cap_data, edata);
    checkOutput({tag, "_tx_lat"},  72'(tx_cyc - req_cyc), 72'(1));
    checkOutput({tag, "_done_lat"}, 72'(done_cyc - req_cyc), 72'(2));
    checkOutput({tag, "_rx_err"},  72'(n_rx + n_err), 72'(0));
    checkOutput({tag, "_busy_end"}, 72'(busy), 72'(0));
  endtask

  task automatic run_read(input logic [31:0] a, input int delay, input logic [4:0] rlen,
                          input logic [71:0] rdat, input string tag);
    logic [4:0]  elen;
    logic [71:0] edata;
    expect_msg(1'b0, a, 32'h0, 4'h0, elen, edata);
    clear_counts();
    applyStimulus(1'b0, a, $urandom, 4'($urandom));
    repeat (delay) tick();
    send_reply(rlen, rdat, 40);
    wait_done(10);
    if (rlen == 5'd4) model_rdata = rdat[31:0];
    checkOutput({tag, "_ntx"},     72'(n_tx), 72'(1));
    checkOutput({tag, "_len"},     72'(cap_len), 72'(elen));
    checkOutput({tag, "_data"},    cap_data, edata);
    checkOutput({tag, "_tx_lat"},  72'(tx_cyc - req_cyc), 72'(1));
    checkOutput({tag, "_rx_lat"},  72'(rx_cyc - reply_cyc), 72'(1));
    checkOutput({tag, "_done_lat"}, 72'(done_cyc - rx_cyc), 72'(1));
    checkOutput({tag, "_nerr"},    72'(n_err), 72'(rlen != 5'd4));
    if (rlen != 5'd4) checkOutput({tag, "_err_before_done"}, 72'(done_cyc - err_cyc), 72'(1));
    checkOutput({tag, "_rdata_at_done"}, 72'(cap_rdata), 72'(model_rdata));
    checkOutput({tag, "_rdata_hold"}, 72'(rdata), 72'(model_rdata));
  endtask

  initial begin
    RST = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wmask = '0;
    tx_ready = 1'b1; rx_valid = 1'b0; rx_len = '0; rx_data = '0;
    cyc = 0; n_rx_back = 0; prev_rx = 1'b0; model_rdata = '0;
    cap_len = '0; cap_data = '0; cap_rdata = '0;
    clear_counts();

    repeat (2) @(negedge EXCLK);
    check_all_zero("reset");
    RST = 1'b0;
    tick();

    run_write(32'h100, 32'hDEADBEEF, 4'b0011, "wr_dir");
    checkOutput("wr_dir_const", cap_data, 72'h03_00000100_DEADBEEF);
    for (int k = 0; k < 6; k++)
      run_write($urandom, $urandom, (k == 0) ? 4'h0 : 4'($urandom), "wr_rand");

    run_read(32'h4, 10, 5'd4, 72'h12345678, "rd_dir");
    checkOutput("rd_dir_const", cap_data, 72'h00_00000004);
    for (int k = 0; k < 5; k++)
      run_read($urandom, $urandom_range(1, 12), 5'd4,
               {$urandom, $urandom, 8'($urandom)}, "rd_rand");

    // Backpressure: the request must wait in SEND without timing out.
    clear_counts();
    tx_ready = 1'b0;
    applyStimulus(1'b1, 32'hA0, 32'h55AA55AA, 4'hF);
    busy_low = 0;
    repeat (50) begin
      tick();
      if (!busy) busy_low++;
    end
    checkOutput("bp_busy_held", 72'(busy_low), 72'(0));
    checkOutput("bp_no_tx", 72'(n_tx), 72'(0));
    tx_ready = 1'b1;
    rel_cyc = cyc;
    wait_done(20);
    checkOutput("bp_ntx", 72'(n_tx), 72'(1));
    checkOutput("bp_tx_lat", 72'(tx_cyc - rel_cyc), 72'(1));
    checkOutput("bp_done_lat", 72'(done_cyc - tx_cyc), 72'(1));
    checkOutput("bp_nerr", 72'(n_err), 72'(0));

    run_read($urandom, 3, 5'd9, {$urandom, $urandom, 8'($urandom)}, "rd_badlen9");
    run_read($urandom, 5, 5'd3, {$urandom, $urandom, 8'($urandom)}, "rd_badlen3");

    // Timeout: no reply at all.
    clear_counts();
    applyStimulus(1'b0, 32'hC0, 32'h0, 4'h0);
    wait_done(TIMEOUT + 20);
    checkOutput("to_nerr", 72'(n_err), 72'(1));
    checkOutput("to_err_lat", 72'(err_cyc - tx_cyc), 72'(TIMEOUT));
    checkOutput("to_done_lat", 72'(done_cyc - err_cyc), 72'(1));
    checkOutput("to_nrx", 72'(n_rx), 72'(0));
    checkOutput("to_rdata", 72'(rdata), 72'(model_rdata));

    // Stray reply while idle.
    clear_counts();
    send_reply(5'd4, {$urandom, $urandom, 8'($urandom)}, 5);
    repeat (3) tick();
    checkOutput("stray_idle_nerr", 72'(n_err), 72'(1));
    checkOutput("stray_idle_err_cyc", 72'(err_cyc - rx_cyc), 72'(0));
    checkOutput("stray_idle_busy", 72'(n_busy), 72'(0));
    checkOutput("stray_idle_done", 72'(n_done), 72'(0));
    checkOutput("stray_idle_rdata", 72'(rdata), 72'(model_rdata));
    run_read($urandom, 4, 5'd4, {$urandom, $urandom, 8'($urandom)}, "rd_after_stray");

    // Stray reply in SEND, popped in the same cycle as the message push.
    clear_counts();
    tx_ready = 1'b0;
    applyStimulus(1'b0, 32'h2000, 32'h0, 4'h0);
    repeat (3) tick();
    tx_ready = 1'b1;
    send_reply(5'd4, 72'hBAD, 5);
    checkOutput("stray_send_same_cyc", 72'(tx_cyc - rx_cyc), 72'(0));
    checkOutput("stray_send_nerr", 72'(n_err), 72'(1));
    checkOutput("stray_send_busy", 72'(busy), 72'(1));
    repeat (2) tick();
    good_data = $urandom;
    send_reply(5'd4, {40'h0, good_data}, 20);
    wait_done(10);
    model_rdata = good_data;
    checkOutput("stray_send_rdata", 72'(cap_rdata), 72'(model_rdata));
    checkOutput("stray_send_nerr_end", 72'(n_err), 72'(1));
    checkOutput("stray_send_nrx", 72'(n_rx), 72'(2));

    // Reset while waiting for a reply.
    run_read($urandom, 2, 5'd4, {40'h0, $urandom | 32'h1}, "rd_pre_rst");
    clear_counts();
    applyStimulus(1'b0, 32'h3000, 32'h0, 4'h0);
    repeat (3) tick();
    checkOutput("rst_pre_busy", 72'(busy), 72'(1));
    #2 RST = 1'b1;
    #1 check_all_zero("rst_mid");
    model_rdata = '0;
    @(negedge EXCLK);
    RST = 1'b0;
    tick();
    clear_counts();
    send_reply(5'd4, {$urandom, $urandom, 8'($urandom)}, 5);
    repeat (2) tick();
    checkOutput("late_nerr", 72'(n_err), 72'(1));
    checkOutput("late_busy", 72'(n_busy), 72'(0));
    checkOutput("late_done", 72'(n_done), 72'(0));
    checkOutput("late_rdata", 72'(rdata), 72'(0));
    run_read($urandom, 6, 5'd4, {$urandom, $urandom, 8'($urandom)}, "rd_after_rst");

    checkOutput("rx_flag_back_to_back", 72'(n_rx_back), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
